// File: rtl/adder_exhaustive_checker_if.sv
// Operand/result bus between the exhaustive checker and the adder under test.
interface adder_exhaustive_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c0;
    logic [WIDTH-1:0] s;
    logic             c8;

    // Checker drives operands and reads the result back.
    modport master (output a, output b, output c0, input s, input c8);
    // Adder consumes operands and returns the result.
    modport slave  (input a, input b, input c0, output s, output c8);
endinterface

// File: rtl/adder_exhaustive_checker.sv
// Hardware exhaustive checker for the carry-look-ahead adder: walks every
// {c0, a, b} vector, compares {c8, s} against a + b + c0, and reports
// pass/fail, the mismatch count and the first failing vector.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// DRIVE | current vector on the adder inputs, settle cycle
// CHECK | adder result compared at the closing edge, then advance/finish
// DONE  | run finished, results held; start restarts immediately
module adder_exhaustive_checker #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    adder_exhaustive_checker_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [2*WIDTH+1:0]         err_count,
    output logic [2*WIDTH:0]           first_fail,
    output logic                       fail_seen
);
    localparam int VW = 2 * WIDTH + 1;
    localparam int CW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec;
    logic [WIDTH:0]  exp_sum;
    logic            mismatch;

    // b is the low field and c0 the top bit, so counting vec walks b fastest.
    assign bus.b  = vec[WIDTH-1:0];
    assign bus.a  = vec[2*WIDTH-1:WIDTH];
    assign bus.c0 = vec[VW-1];

    // Reference sum of the vector currently driven, and the compare against the adder.
    always_comb begin
        exp_sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c0};
        mismatch = ({bus.c8, bus.s} != exp_sum);
    end

    // Sequencing FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + CW'(1);
                        if (!fail_seen) begin
                            fail_seen  <= 1'b1;
                            first_fail <= vec;
                        end
                    end
                    if (vec == '1) begin
                        // vec stays at all-ones; pass must include this last vector's result.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec   <= vec + VW'(1);
                        state <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Self-checking bench for adder_exhaustive_checker at a reduced width so that
// full runs stay short. A behavioural adder with selectable faults stands in
// for the real adder; expectations come from plain integer arithmetic.
module tb_adder_exhaustive_checker;
    localparam int W  = 4;
    localparam int VW = 2 * W + 1;
    localparam int CW = 2 * W + 2;
    localparam int N  = 1 << VW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass, fail_seen;
    logic [CW-1:0] err_count;
    logic [VW-1:0] first_fail;

    int            fault_mode = 0;
    logic          fmap [N];
    logic [W:0]    adder_r;

    int tests  = 0;
    int failed = 0;

    adder_exhaustive_checker_if #(.WIDTH(W)) bus ();

    adder_exhaustive_checker #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    always #5 clk = ~clk;

    // Stand-in adder: 0 good, 1 s[0] stuck 0, 2 ignores c0, 3 c8 inverted, 4 flips s[0] where fmap set
    function automatic logic [W:0] adder_out(int mode, logic [VW-1:0] v, logic flip);
        logic [W:0] r;
        r = {1'b0, v[2*W-1:W]} + {1'b0, v[W-1:0]} + {{W{1'b0}}, v[VW-1]};
        case (mode)
            1: r[0] = 1'b0;
            2: r = {1'b0, v[2*W-1:W]} + {1'b0, v[W-1:0]};
            3: r[W] = ~r[W];
            4: if (flip) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        adder_r = adder_out(fault_mode, {bus.c0, bus.a, bus.b}, fmap[{bus.c0, bus.a, bus.b}]);
        bus.s   = adder_r[W-1:0];
        bus.c8  = adder_r[W];
    end

    // Model: a vector fails when the adder's answer differs from the integer a + b + c0.
    function automatic bit vec_fails(int mode, int v);
        int av, bv, cv;
        av = (v >> W) & ((1 << W) - 1);
        bv = v & ((1 << W) - 1);
        cv = v >> (2 * W);
        return int'(adder_out(mode, VW'(v), fmap[v])) != (av + bv + cv);
    endfunction

    task automatic model_totals(input int mode, output int total, output int first);
        total = 0;
        first = 0;
        for (int v = 0; v < N; v++) begin
            if (vec_fails(mode, v)) begin
                if (total == 0) first = v;
                total++;
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " vec"},        longint'({bus.c0, bus.a, bus.b}), 0);
        check({name, " busy"},       longint'(busy), 0);
        check({name, " done"},       longint'(done), 0);
        check({name, " pass"},       longint'(pass), 0);
        check({name, " err_count"},  longint'(err_count), 0);
        check({name, " first_fail"}, longint'(first_fail), 0);
        check({name, " fail_seen"},  longint'(fail_seen), 0);
    endtask

    // Full run with per-cycle compare; style 0 pulses start, 1 holds it, 2 toggles it randomly.
    task automatic run_check(input string name, input int mode, input int style);
        int total, first, cnt, ffirst, bad, exp_vec;
        bit ok;
        string note;
        model_totals(mode, total, first);
        fault_mode = mode;
        cnt = 0; ffirst = 0; bad = 0; note = "";
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t <= 2 * N; t++) begin
            @(negedge clk);
            if (t > 0 && (t % 2) == 0) begin
                if (vec_fails(mode, t / 2 - 1)) begin
                    if (cnt == 0) ffirst = t / 2 - 1;
                    cnt++;
                end
            end
            exp_vec = (t < 2 * N) ? t / 2 : N - 1;
            ok = ({bus.c0, bus.a, bus.b} == VW'(exp_vec)) &&
                 (busy == (t < 2 * N)) &&
                 (done == (t == 2 * N)) &&
                 (pass == (t == 2 * N && cnt == 0)) &&
                 (err_count == CW'(cnt)) &&
                 (fail_seen == (cnt > 0)) &&
                 (first_fail == VW'(ffirst));
            if (!ok) begin
                bad++;
                if (bad == 1)
                    note = $sformatf("t=%0d vec=%0h busy=%0b done=%0b pass=%0b err=%0d first=%0h, expected vec=%0h err=%0d first=%0h",
                                     t, {bus.c0, bus.a, bus.b}, busy, done, pass, err_count, first_fail,
                                     exp_vec, cnt, ffirst);
            end
            case (style)
                1:       start = 1'b1;
                2:       start = (t < 2 * N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                default: start = 1'b0;
            endcase
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL %s trace: %0d bad cycles, first %s", name, bad, note);
        end
        check({name, " err_count"}, longint'(err_count), total);
        check({name, " first_fail"}, longint'(first_fail), first);
        check({name, " pass"}, longint'(pass), (total == 0) ? 1 : 0);
    endtask

    initial begin
        int tot, fst, idx;
        for (int v = 0; v < N; v++) fmap[v] = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle without start busy", longint'(busy), 0);

        // Hand-computed totals at W=4 pin the model.
        model_totals(0, tot, fst); check("model good total", tot, 0);
        model_totals(1, tot, fst); check("model s0 total", tot, 256); check("model s0 first", fst, 'h001);
        model_totals(2, tot, fst); check("model c0 total", tot, 256); check("model c0 first", fst, 'h100);
        model_totals(3, tot, fst); check("model c8 total", tot, 512); check("model c8 first", fst, 'h000);

        run_check("clean", 0, 0);
        check("clean done", longint'(done), 1);
        check("clean fail_seen", longint'(fail_seen), 0);

        run_check("s0 stuck", 1, 0);
        check("s0 err literal", longint'(err_count), 256);
        check("s0 first literal", longint'(first_fail), 'h001);

        run_check("ignore c0", 2, 0);
        check("c0 err literal", longint'(err_count), 256);
        check("c0 first literal", longint'(first_fail), 'h100);

        run_check("c8 inverted", 3, 0);
        check("c8 err literal", longint'(err_count), 512);
        check("c8 fail_seen", longint'(fail_seen), 1);

        for (int v = 0; v < N; v++) fmap[v] = ($urandom_range(0, 7) == 0);
        run_check("random faults toggle start", 4, 2);

        for (int v = 0; v < N; v++) fmap[v] = 1'b0;
        idx = int'($urandom_range(0, N - 1));
        fmap[idx] = 1'b1;
        run_check("single random fault", 4, 0);
        check("single fault first", longint'(first_fail), idx);
        check("single fault count", longint'(err_count), 1);

        // Abort mid-run at vector 0x0AB with errors already accumulated.
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t <= 2 * 'h0AB; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-abort vec", longint'({bus.c0, bus.a, bus.b}), 'h0AB);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort stays idle busy", longint'(busy), 0);
        check("abort stays idle vec", longint'({bus.c0, bus.a, bus.b}), 0);
        run_check("after abort", 0, 0);

        // start held high: done lasts one cycle, then the restart clears everything.
        run_check("hold start", 1, 1);
        @(negedge clk);
        check("restart done", longint'(done), 0);
        check("restart busy", longint'(busy), 1);
        check("restart vec", longint'({bus.c0, bus.a, bus.b}), 0);
        check("restart err_count", longint'(err_count), 0);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/adder_exhaustive_checker.md
# adder_exhaustive_checker

Synthesizable stimulus generator and response checker for the team's 8-bit carry-look-ahead adder. It drives every {c0, a, b} combination into the adder's ports and compares the returned {c8, s} against a + b + c0. It reports pass/fail, an error count and the first failing vector. It sits beside the adder on the FPGA board, so the exhaustive check runs in hardware instead of only in simulation.

## Interface

Parameters:
- WIDTH, 8, operand width; vector space is 2^(2*WIDTH+1) (131072 at default)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled request to begin a run
- a  out  WIDTH  operand A to adder
- b  out  WIDTH  operand B to adder
- c0  out  1  carry-in to adder
- s  in  WIDTH  sum from adder
- c8  in  1  carry-out from adder
- busy  out  1  high while a run is in progress
- done  out  1  high after a run completes, held until next run or reset
- pass  out  1  valid when done; 1 iff err_count == 0
- err_count  out  2*WIDTH+2  number of mismatching vectors; cannot overflow (max 2^(2*WIDTH+1))
- first_fail  out  2*WIDTH+1  {c0, a, b} of first mismatch; valid when err_count != 0
- fail_seen  out  1  sticky, set on first mismatch of current run

## Operation

- Internal vector register vec[2*WIDTH:0] drives outputs: {c0, a, b} = vec. Order matches the simulation bench: vec counts 0 -> 2^(2*WIDTH+1)-1. b is the LSBs and c0 is the MSB.
- Expected value: exp = a + b + c0, computed at WIDTH+1 bits. Mismatch iff {c8, s} !== exp[WIDTH:0].
- FSM states:
  - IDLE: busy=0. On start=1, clear vec, err_count, fail_seen, first_fail and done, then go to DRIVE.
  - DRIVE: vector is on the outputs, one settle cycle, then go to CHECK.
  - CHECK: compare at the closing edge.
    - On mismatch: err_count += 1. If fail_seen==0, set fail_seen=1 and load first_fail=vec.
    - If vec == all-ones, go to DONE. Otherwise vec += 1 and go to DRIVE.
  - DONE: busy=0, done=1, pass=(err_count==0). On start=1, clear as in IDLE and go to DRIVE (restart). Otherwise stay.
- start is ignored in DRIVE and CHECK. Holding start high does not disturb a run. Holding start high through DONE restarts immediately.
- The last vector is checked before DONE. vec does not wrap; it holds all-ones in DONE.
- pass is 0 whenever done=0.

## Timing

- Reset (rst_n=0, async) puts the FSM in IDLE. All outputs go to 0: a, b, c0, busy, done, pass, err_count, first_fail, fail_seen.
- start seen at edge k: busy=1 and vector 0 on the outputs from edge k, so the state is DRIVE during cycle k+1.
- Each vector is held 2 cycles (DRIVE + CHECK). The adder is combinational, and its outputs are sampled at the CHECK-closing edge.
- A full run keeps busy=1 for exactly 2 * 2^(2*WIDTH+1) cycles (262144 at default). done=1 and busy=0 on the same edge that checks the last vector.
- err_count and first_fail update on the CHECK edge of the failing vector, so they are visible the next cycle.
- rst_n low mid-run aborts immediately: outputs return to reset values and no partial result is retained.
- A restart from DONE clears done, pass and the counters on the same edge that re-enters DRIVE.

## Test plan

- Correct behavioral adder connected, start pulse: busy high for 262144 cycles, then done=1, pass=1, err_count=0, fail_seen=0.
- Adder with s[0] stuck at 0: done=1, pass=0, err_count=65536, first_fail=17'h00001 (a=0, b=1, c0=0).
- Adder ignoring c0: err_count=65536, first_fail=17'h10000.
- Adder with c8 inverted: err_count=131072, first_fail=17'h00000, fail_seen=1.
- Pulse rst_n low at vector 0x0ABCD mid-run: all outputs 0 and state IDLE. A new start gives a complete run with results identical to the clean-run case.
- Hold start high continuously: run completes, and done is high for exactly 1 cycle before restart clears it. start toggling during busy changes neither the vec sequence nor the run length.
